// File: rtl/gray_conv_arbiter.sv
// Four-requester round-robin arbiter that converts the winner's Gray word to binary
// and holds the result under a valid/ready handshake.
module gray_conv_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic [3:0]           req_in,
  input  logic [4*WIDTH-1:0]   gray_in,
  input  logic                 ready_in,
  output logic [3:0]           grant_out,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     bin_out,
  output logic [1:0]           id_out,
  output logic                 busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_win;
  logic [WIDTH-1:0] r_gray;
  logic [3:0]       r_grant;
  logic             r_valid;
  logic [WIDTH-1:0] r_bin;
  logic [1:0]       r_id;
  logic             r_busy;

  logic [1:0]       w_winner;
  logic [WIDTH-1:0] w_slice;

  // Rotate requests so the pointer lands on bit 0, then take the lowest set bit.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {req, req} >> ptr;
    rot = dbl[3:0];
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return ptr + off;
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Winner selection and slice extraction for the current request vector.
  always_comb begin
    w_winner = rr_pick(req_in, r_ptr);
    w_slice  = gray_in[int'(w_winner)*WIDTH +: WIDTH];
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_win   <= 2'd0;
      r_gray  <= '0;
      r_grant <= 4'd0;
      r_valid <= 1'b0;
      r_bin   <= '0;
      r_id    <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_in) begin
            r_grant <= 4'b0001 << w_winner;
            r_gray  <= w_slice;
            r_win   <= w_winner;
            r_ptr   <= w_winner + 2'd1;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_grant <= 4'd0;
          r_bin   <= gray2bin(r_gray);
          r_id    <= r_win;
          r_valid <= 1'b1;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ready_in) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= 4'd0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_out = r_grant;
  assign valid_out = r_valid;
  assign bin_out   = r_bin;
  assign id_out    = r_id;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: conversion table, fairness, backpressure
// and reset sequences, with a queue of expected results checked when valid_out rises.
module tb_gray_conv_arbiter;
  localparam int W = 3;

  logic           clk_in = 1'b0;
  logic           rstn_in;
  logic [3:0]     req_in;
  logic [4*W-1:0] gray_in;
  logic           ready_in;
  logic [3:0]     grant_out;
  logic           valid_out;
  logic [W-1:0]   bin_out;
  logic [1:0]     id_out;
  logic           busy_out;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .rstn_in  (rstn_in),
    .req_in   (req_in),
    .gray_in  (gray_in),
    .ready_in (ready_in),
    .grant_out(grant_out),
    .valid_out(valid_out),
    .bin_out  (bin_out),
    .id_out   (id_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] bin;
  } exp_t;

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference conversion: binary bit k is the XOR of all Gray bits at or above k.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int k = 0; k < W; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_bin"}, 32'(bin_out), 32'(e.bin));
      chk({name, "_id"},  32'(id_out),  32'(e.id));
    end
  endtask

  // One full transaction with ready held high; the requester drops its request on grant.
  task automatic run_txn(input string name, input logic [3:0] req, input logic [4*W-1:0] g,
                         input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                         input logic [W-1:0] exp_bin);
    exp_t e;
    bit   found;
    req_in  = req;
    gray_in = g;
    e.id = exp_id;
    e.bin = exp_bin;
    sb.push_back(e);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (grant_out != 4'd0) found = 1'b1;
    end
    chk({name, "_grant_seen"}, 32'(found), 32'd1);
    chk({name, "_grant"}, 32'(grant_out), 32'(exp_gnt));
    chk({name, "_busy"}, 32'(busy_out), 32'd1);
    req_in = req & ~exp_gnt;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (valid_out) found = 1'b1;
    end
    chk({name, "_valid_seen"}, 32'(found), 32'd1);
    chk({name, "_grant_pulse"}, 32'(grant_out), 32'd0);
    chk_result(name);
    tick();
    chk({name, "_valid_drop"}, 32'(valid_out), 32'd0);
    chk({name, "_busy_drop"}, 32'(busy_out), 32'd0);
  endtask

  initial begin
    vecs[0] = '{gray: 3'b000, bin: 3'b000};
    vecs[1] = '{gray: 3'b001, bin: 3'b001};
    vecs[2] = '{gray: 3'b011, bin: 3'b010};
    vecs[3] = '{gray: 3'b010, bin: 3'b011};
    vecs[4] = '{gray: 3'b110, bin: 3'b100};
    vecs[5] = '{gray: 3'b111, bin: 3'b101};
    vecs[6] = '{gray: 3'b101, bin: 3'b110};
    vecs[7] = '{gray: 3'b100, bin: 3'b111};

    rstn_in  = 1'b0;
    req_in   = 4'b1111;
    gray_in  = 12'hFFF;
    ready_in = 1'b1;

    // Reset held two cycles with every request active.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_grant", 32'(grant_out), 32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_bin",   32'(bin_out),   32'd0);
      chk("rst_id",    32'(id_out),    32'd0);
      chk("rst_busy",  32'(busy_out),  32'd0);
    end
    rstn_in = 1'b1;
    req_in  = 4'b0000;
    tick();
    chk("idle_grant", 32'(grant_out), 32'd0);

    run_txn("single", 4'b0100, {3'b000, 3'b110, 3'b000, 3'b000}, 4'b0100, 2'd2, 3'b100);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("conv%0d", i), 4'b0001, {9'd0, vecs[i].gray}, 4'b0001, 2'd0,
              vecs[i].bin);
    end

    // Fairness from a fresh pointer: four requests held continuously.
    rstn_in = 1'b0;
    tick();
    rstn_in = 1'b1;
    begin
      logic [1:0] order[5];
      int ng;
      int last_cyc;
      exp_t e;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
      ng = 0;
      last_cyc = 0;
      req_in  = 4'b1111;
      gray_in = {3'b100, 3'b101, 3'b111, 3'b011};
      for (int c = 1; c <= 40 && !(ng == 5 && sb.size() == 0); c++) begin
        tick();
        if (grant_out != 4'd0) begin
          if (ng < 5) begin
            chk($sformatf("fair_grant%0d", ng), 32'(grant_out), 32'(4'b0001 << order[ng]));
            if (ng > 0) chk($sformatf("fair_gap%0d", ng), 32'(c - last_cyc), 32'd3);
            e.id  = order[ng];
            e.bin = ref_g2b(gray_in[int'(order[ng])*W +: W]);
            sb.push_back(e);
          end else begin
            chk("fair_extra_grant", 32'(grant_out), 32'd0);
          end
          last_cyc = c;
          ng++;
        end
        if (valid_out) chk_result("fair");
      end
      chk("fair_count", 32'(ng), 32'd5);
      req_in = 4'b0000;
      tick();
      tick();
      chk("fair_idle", 32'(busy_out), 32'd0);
    end

    // Backpressure: result must hold while ready is low.
    ready_in = 1'b0;
    req_in   = 4'b0100;
    gray_in  = {3'b000, 3'b110, 3'b000, 3'b000};
    sb.push_back('{id: 2'd2, bin: ref_g2b(3'b110)});
    tick();
    chk("bp_grant", 32'(grant_out), 32'b0100);
    req_in = 4'b0000;
    tick();
    chk("bp_valid", 32'(valid_out), 32'd1);
    chk_result("bp");
    for (int c = 0; c < 5; c++) begin
      req_in = 4'b1111;
      tick();
      chk("bp_hold_valid", 32'(valid_out), 32'd1);
      chk("bp_hold_bin",   32'(bin_out),   32'b100);
      chk("bp_hold_id",    32'(id_out),    32'd2);
      chk("bp_hold_grant", 32'(grant_out), 32'd0);
      chk("bp_hold_busy",  32'(busy_out),  32'd1);
    end
    req_in   = 4'b0000;
    ready_in = 1'b1;
    tick();
    chk("bp_release_valid", 32'(valid_out), 32'd0);
    chk("bp_release_busy",  32'(busy_out),  32'd0);
    chk("bp_release_bin",   32'(bin_out),   32'b100);

    // Reset during HOLD clears everything and rewinds the pointer.
    ready_in = 1'b0;
    req_in   = 4'b1000;
    gray_in  = {3'b111, 3'b000, 3'b101, 3'b000};
    tick();
    chk("mid_grant", 32'(grant_out), 32'b1000);
    req_in = 4'b0000;
    tick();
    chk("mid_valid", 32'(valid_out), 32'd1);
    tick();
    rstn_in = 1'b0;
    tick();
    chk("mid_rst_grant", 32'(grant_out), 32'd0);
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_bin",   32'(bin_out),   32'd0);
    chk("mid_rst_id",    32'(id_out),    32'd0);
    chk("mid_rst_busy",  32'(busy_out),  32'd0);
    rstn_in  = 1'b1;
    ready_in = 1'b1;
    req_in   = 4'b1010;
    sb.push_back('{id: 2'd1, bin: ref_g2b(3'b101)});
    tick();
    chk("mid_next_grant", 32'(grant_out), 32'b0010);
    req_in = 4'b0000;
    tick();
    chk("mid_next_valid", 32'(valid_out), 32'd1);
    chk_result("mid_next");
    tick();
    chk("mid_next_done", 32'(valid_out), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
